// File: rtl/snn_pkg.sv
// Shared types and helpers for the time-multiplexed LIF neuron scheduler.
// Holds the scheduler FSM encoding and the neuron index width calculation.
// No logic of its own; imported by the scheduler and its datapath.
package snn_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        EMIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Width of a neuron index; never below 1 so a one-bit port always exists.
    function automatic int idx_width(input int num_neurons);
        return (num_neurons > 1) ? $clog2(num_neurons) : 1;
    endfunction

endpackage

// File: rtl/snn_lif_update.sv
// Purpose: one leaky-integrate-and-fire step for a single neuron.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller decides when the result is committed.
// Ports: potential/synaptic_input (W bits) in; next_potential (W bits) and
//        fire out. next_potential is the leaked value before any spike reset.
module snn_lif_update #(
    parameter int unsigned W         = 8,
    parameter int unsigned THRESHOLD = 8,
    parameter int unsigned DECAY     = 1
) (
    input  logic [W-1:0] potential,
    input  logic [W-1:0] synaptic_input,
    output logic [W-1:0] next_potential,
    output logic         fire
);

    localparam logic [31:0] TH32  = 32'(THRESHOLD);
    localparam logic [31:0] DEC32 = 32'(DECAY);

    logic [W:0]   sum;
    logic [W-1:0] sat;
    logic [31:0]  sat32;

    always_comb begin
        // One extra bit catches the carry; on overflow clamp to all ones.
        sum   = {1'b0, potential} + {1'b0, synaptic_input};
        sat   = sum[W] ? {W{1'b1}} : sum[W-1:0];
        sat32 = 32'(sat);
        // Leak floors at zero rather than wrapping.
        next_potential = (sat32 >= DEC32) ? W'(sat32 - DEC32) : '0;
        fire           = (32'(next_potential) >= TH32);
    end

endmodule

// File: rtl/snn_neuron_scheduler.sv
// Purpose: sweeps NUM_NEURONS stored potentials through one shared LIF datapath.
// Latency: 1 cycle per non-spiking neuron, >=2 per spiking neuron; sweep >= N+2.
// Backpressure: input accepted only in FETCH; a spike holds EMIT until spike_ready.
// Ports: clk/reset (sync, active high); start kicks a sweep from IDLE;
//        input_valid/input_ready/synaptic_input feed the current neuron;
//        spike_valid/spike_ready/spike_id carry spike events; busy, done status.
module snn_neuron_scheduler
    import snn_pkg::*;
#(
    parameter int unsigned NUM_NEURONS              = 8,
    parameter int unsigned MEMBRANE_POTENTIAL_WIDTH = 8,
    parameter int unsigned MEMBRANE_THRESHOLD       = 8,
    parameter int unsigned MEMBRANE_DECAY           = 1
) (
    input  logic                                    clk,
    input  logic                                    reset,
    input  logic                                    start,
    input  logic                                    input_valid,
    output logic                                    input_ready,
    input  logic [MEMBRANE_POTENTIAL_WIDTH-1:0]     synaptic_input,
    output logic                                    spike_valid,
    input  logic                                    spike_ready,
    output logic [idx_width(NUM_NEURONS)-1:0]       spike_id,
    output logic                                    busy,
    output logic                                    done
);

    localparam int IW = idx_width(NUM_NEURONS);
    localparam int W  = MEMBRANE_POTENTIAL_WIDTH;

    state_t          state_q, state_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [IW-1:0]   spike_id_q, spike_id_d;
    logic [W-1:0]    pot_q [NUM_NEURONS];
    logic [W-1:0]    pot_d [NUM_NEURONS];

    logic [W-1:0]    lif_next;
    logic            lif_fire;
    logic            last_idx;

    assign last_idx = (idx_q == IW'(NUM_NEURONS - 1));

    snn_lif_update #(
        .W         (W),
        .THRESHOLD (MEMBRANE_THRESHOLD),
        .DECAY     (MEMBRANE_DECAY)
    ) u_lif (
        .potential      (pot_q[idx_q]),
        .synaptic_input (synaptic_input),
        .next_potential (lif_next),
        .fire           (lif_fire)
    );

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        spike_id_d = spike_id_q;
        pot_d      = pot_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    idx_d   = '0;
                    state_d = FETCH;
                end
            end
            FETCH: begin
                if (input_valid) begin
                    if (lif_fire) begin
                        // Spiking neuron resets; the index moves on only
                        // after the spike event has been handed off.
                        pot_d[idx_q] = '0;
                        spike_id_d   = idx_q;
                        state_d      = EMIT;
                    end else begin
                        pot_d[idx_q] = lif_next;
                        if (last_idx) begin
                            state_d = DONE;
                        end else begin
                            idx_d   = idx_q + IW'(1);
                            state_d = FETCH;
                        end
                    end
                end
            end
            EMIT: begin
                if (spike_ready) begin
                    if (last_idx) begin
                        state_d = DONE;
                    end else begin
                        idx_d   = idx_q + IW'(1);
                        state_d = FETCH;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            spike_id_q <= '0;
            for (int i = 0; i < NUM_NEURONS; i++) begin
                pot_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            spike_id_q <= spike_id_d;
            pot_q      <= pot_d;
        end
    end

    assign input_ready = (state_q == FETCH);
    assign spike_valid = (state_q == EMIT);
    assign done        = (state_q == DONE);
    assign busy        = (state_q != IDLE);
    assign spike_id    = spike_id_q;

endmodule

// File: tb/tb_snn_neuron_scheduler.sv
module tb_snn_neuron_scheduler;

    localparam int N = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       input_valid = 1'b0;
    logic       spike_ready = 1'b0;
    logic [7:0] synaptic_input = 8'd0;
    logic       input_ready, spike_valid, busy, done;
    logic [1:0] spike_id;

    snn_neuron_scheduler #(
        .NUM_NEURONS              (N),
        .MEMBRANE_POTENTIAL_WIDTH (8),
        .MEMBRANE_THRESHOLD       (8),
        .MEMBRANE_DECAY           (1)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .input_valid    (input_valid),
        .input_ready    (input_ready),
        .synaptic_input (synaptic_input),
        .spike_valid    (spike_valid),
        .spike_ready    (spike_ready),
        .spike_id       (spike_id),
        .busy           (busy),
        .done           (done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference state: plain integer potentials and expected spike order.
    int model_pot [N];
    int exp_spk [$];
    int got_spk [$];
    int got_cyc;
    bit got_ok, bp_bad, excl_bad;

    function automatic int lif_ref(input int p, input int x, output bit fire);
        int s, n;
        s = p + x;
        if (s > 255) s = 255;
        n = (s >= 1) ? s - 1 : 0;
        fire = (n >= 8);
        return fire ? 0 : n;
    endfunction

    // Applies one sweep to the model; returns expected start..done cycle count.
    function automatic int model_sweep(input int ins [N], input int bp);
        bit f;
        int cyc;
        cyc = N + 2;
        exp_spk.delete();
        for (int i = 0; i < N; i++) begin
            model_pot[i] = lif_ref(model_pot[i], ins[i], f);
            if (f) begin
                exp_spk.push_back(i);
                cyc += 1 + bp;
            end
        end
        return cyc;
    endfunction

    function automatic void model_clear();
        for (int i = 0; i < N; i++) model_pot[i] = 0;
    endfunction

    function automatic int spk_code(input int q [$]);
        int c;
        c = 0;
        foreach (q[i]) c = c * 16 + q[i] + 1;
        return c;
    endfunction

    function automatic logic [31:0] pots_dut();
        return {dut.pot_q[3], dut.pot_q[2], dut.pot_q[1], dut.pot_q[0]};
    endfunction

    function automatic logic [31:0] pots_model();
        logic [31:0] v;
        v = '0;
        for (int i = N - 1; i >= 0; i--) v = (v << 8) | 32'(model_pot[i]);
        return v;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; start = 1'b0; input_valid = 1'b0; spike_ready = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        model_clear();
    endtask

    // Drives one sweep; start is the first cycle (1), done is counted inclusively.
    task automatic run_sweep(input int ins [N], input int bp, input bit poke_start);
        int hs, wc, held;
        hs = 0; wc = 0; held = 0;
        got_spk.delete();
        got_ok = 0; bp_bad = 0; excl_bad = 0;
        @(negedge clk);
        start = 1'b1; input_valid = 1'b0; spike_ready = 1'b0;
        got_cyc = 1;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            got_cyc++;
            start = poke_start && (got_cyc == 3 || got_cyc == 4);
            input_valid = 1'b0;
            spike_ready = 1'b0;
            if (int'(input_ready) + int'(spike_valid) + int'(done) != 1) excl_bad = 1;
            if (busy !== 1'b1) excl_bad = 1;
            if (done) begin
                got_ok = 1;
                break;
            end
            if (input_ready && hs < N) begin
                input_valid = 1'b1;
                synaptic_input = 8'(ins[hs]);
                hs++;
            end
            if (spike_valid) begin
                if (wc == 0) begin
                    got_spk.push_back(int'(spike_id));
                    held = int'(spike_id);
                end else if (int'(spike_id) != held || input_ready !== 1'b0) begin
                    bp_bad = 1;
                end
                if (wc >= bp) begin
                    spike_ready = 1'b1;
                    wc = 0;
                end else begin
                    wc++;
                end
            end
        end
        start = 1'b0; input_valid = 1'b0; spike_ready = 1'b0;
        @(negedge clk);
        if (done !== 1'b0 || busy !== 1'b0) excl_bad = 1;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b1; input_valid = 1'b1; spike_ready = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({busy, input_ready, spike_valid, done, spike_id} !== 6'b0) begin
            errors++;
            $display("FAIL reset_outputs: got %b expected 000000",
                     {busy, input_ready, spike_valid, done, spike_id});
        end
        checks++;
        if (pots_dut() !== 32'h0) begin
            errors++;
            $display("FAIL reset_pots: got %h expected 00000000", pots_dut());
        end
        reset = 1'b0; start = 1'b0; input_valid = 1'b0; spike_ready = 1'b0;
        model_clear();
        repeat (2) @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_start_priority: busy=%b expected 0", busy);
        end
    endtask

    task automatic test_basic_sweep();
        int ec;
        ec = model_sweep('{3, 3, 3, 3}, 0);
        run_sweep('{3, 3, 3, 3}, 0, 0);
        checks++;
        if (!got_ok || got_cyc != ec || ec != 6) begin
            errors++;
            $display("FAIL basic_len: got %0d cycles (ok=%0d) expected 6", got_cyc, got_ok);
        end
        checks++;
        if (got_spk.size() != 0) begin
            errors++;
            $display("FAIL basic_nospike: got %0d spikes expected 0", got_spk.size());
        end
        checks++;
        if (pots_dut() !== 32'h02020202) begin
            errors++;
            $display("FAIL basic_pots: got %h expected 02020202", pots_dut());
        end
        checks++;
        if (excl_bad) begin
            errors++;
            $display("FAIL basic_status: got bad status flags expected clean");
        end
    endtask

    task automatic test_spike_sweep();
        int ec;
        ec = model_sweep('{7, 0, 7, 0}, 0);
        run_sweep('{7, 0, 7, 0}, 0, 0);
        checks++;
        if (!got_ok || got_cyc != ec) begin
            errors++;
            $display("FAIL spike_len: got %0d cycles (ok=%0d) expected %0d", got_cyc, got_ok, ec);
        end
        checks++;
        if (spk_code(got_spk) != spk_code(exp_spk)) begin
            errors++;
            $display("FAIL spike_ids: got code %h expected %h", spk_code(got_spk), spk_code(exp_spk));
        end
        checks++;
        if (pots_dut() !== pots_model()) begin
            errors++;
            $display("FAIL spike_pots: got %h expected %h", pots_dut(), pots_model());
        end
    endtask

    task automatic test_saturation();
        int ec;
        do_reset();
        ec = model_sweep('{3, 3, 3, 3}, 0);
        run_sweep('{3, 3, 3, 3}, 0, 0);
        ec = model_sweep('{255, 0, 0, 0}, 0);
        run_sweep('{255, 0, 0, 0}, 0, 0);
        checks++;
        if (spk_code(got_spk) != spk_code(exp_spk) || got_cyc != ec) begin
            errors++;
            $display("FAIL sat_spike: got code %h/%0d cycles expected %h/%0d",
                     spk_code(got_spk), got_cyc, spk_code(exp_spk), ec);
        end
        checks++;
        if (pots_dut() !== pots_model()) begin
            errors++;
            $display("FAIL sat_pots: got %h expected %h", pots_dut(), pots_model());
        end
    endtask

    task automatic test_backpressure();
        int ec;
        ec = model_sweep('{20, 0, 0, 0}, 5);
        run_sweep('{20, 0, 0, 0}, 5, 0);
        checks++;
        if (!got_ok || got_cyc != ec) begin
            errors++;
            $display("FAIL bp_len: got %0d cycles expected %0d", got_cyc, ec);
        end
        checks++;
        if (bp_bad || excl_bad) begin
            errors++;
            $display("FAIL bp_hold: got unstable=%0d status=%0d expected 0/0", bp_bad, excl_bad);
        end
        checks++;
        if (spk_code(got_spk) != spk_code(exp_spk) || pots_dut() !== pots_model()) begin
            errors++;
            $display("FAIL bp_result: got %h/%h expected %h/%h",
                     spk_code(got_spk), pots_dut(), spk_code(exp_spk), pots_model());
        end
    endtask

    task automatic test_floor_ignore();
        int ec;
        bit extra;
        do_reset();
        ec = model_sweep('{0, 0, 0, 0}, 0);
        run_sweep('{0, 0, 0, 0}, 0, 1);
        checks++;
        if (!got_ok || got_cyc != ec || pots_dut() !== 32'h0 || got_spk.size() != 0) begin
            errors++;
            $display("FAIL floor: got %0d cycles pots %h expected %0d cycles pots 0", got_cyc, pots_dut(), ec);
        end
        extra = 0;
        repeat (4) begin
            @(negedge clk);
            if (busy !== 1'b0 || input_ready !== 1'b0) extra = 1;
        end
        checks++;
        if (extra || excl_bad) begin
            errors++;
            $display("FAIL ignore_start: got second sweep activity expected idle");
        end
    endtask

    task automatic test_reset_mid_emit();
        int ec;
        do_reset();
        ec = model_sweep('{3, 3, 3, 3}, 0);
        run_sweep('{3, 3, 3, 3}, 0, 0);
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0; input_valid = 1'b1; synaptic_input = 8'd3;
        @(negedge clk); synaptic_input = 8'd20;
        @(negedge clk); input_valid = 1'b0; spike_ready = 1'b0;
        checks++;
        if (spike_valid !== 1'b1 || spike_id !== 2'd1) begin
            errors++;
            $display("FAIL emit_entry: got valid=%b id=%0d expected valid=1 id=1", spike_valid, spike_id);
        end
        reset = 1'b1; spike_ready = 1'b1; start = 1'b1;
        @(negedge clk);
        reset = 1'b0; spike_ready = 1'b0; start = 1'b0;
        model_clear();
        checks++;
        if ({busy, input_ready, spike_valid, done, spike_id} !== 6'b0 || pots_dut() !== 32'h0) begin
            errors++;
            $display("FAIL mid_reset: got status %b pots %h expected 0/0",
                     {busy, input_ready, spike_valid, done, spike_id}, pots_dut());
        end
        ec = model_sweep('{0, 0, 0, 0}, 0);
        run_sweep('{0, 0, 0, 0}, 0, 0);
        checks++;
        if (!got_ok || got_cyc != ec || got_spk.size() != 0) begin
            errors++;
            $display("FAIL post_reset_sweep: got %0d cycles %0d spikes expected %0d/0",
                     got_cyc, got_spk.size(), ec);
        end
    endtask

    task automatic test_random();
        int ins [N];
        int bp, ec;
        for (int r = 0; r < 8; r++) begin
            for (int i = 0; i < N; i++) ins[i] = int'($urandom_range(0, 12));
            bp = int'($urandom_range(0, 3));
            ec = model_sweep(ins, bp);
            run_sweep(ins, bp, 0);
            checks++;
            if (!got_ok || got_cyc != ec || spk_code(got_spk) != spk_code(exp_spk)) begin
                errors++;
                $display("FAIL rand_sweep%0d: got %0d cycles code %h expected %0d cycles code %h",
                         r, got_cyc, spk_code(got_spk), ec, spk_code(exp_spk));
            end
            checks++;
            if (pots_dut() !== pots_model() || bp_bad || excl_bad) begin
                errors++;
                $display("FAIL rand_pots%0d: got %h expected %h (flags %0d%0d)",
                         r, pots_dut(), pots_model(), bp_bad, excl_bad);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic_sweep();
        test_spike_sweep();
        test_saturation();
        test_backpressure();
        test_floor_ignore();
        test_reset_mid_emit();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/snn_neuron_scheduler.md
SNN_NEURON_SCHEDULER -- requirements
Module: snn_neuron_scheduler

Interface
REQ-001 Parameter NUM_NEURONS, default 8: number of time-multiplexed neurons, power of two, at least 2.
REQ-002 Parameter MEMBRANE_POTENTIAL_WIDTH, default 8: width of potential and synaptic input.
REQ-003 Parameter MEMBRANE_THRESHOLD, default 8: spike threshold, unsigned.
REQ-004 Parameter MEMBRANE_DECAY, default 1: leak subtracted per timestep, unsigned.
REQ-005 clk  input  1  the single clock; all state updates on its rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 start  input  1  request one timestep sweep over all neurons.
REQ-008 input_valid  input  1  synaptic_input carries data for the current neuron.
REQ-009 input_ready  output  1  scheduler accepts synaptic_input this cycle.
REQ-010 synaptic_input  input  MEMBRANE_POTENTIAL_WIDTH  summed synaptic input for the current neuron.
REQ-011 spike_valid  output  1  spike event pending.
REQ-012 spike_ready  input  1  downstream accepts the spike event.
REQ-013 spike_id  output  log2(NUM_NEURONS)  index of the spiking neuron.
REQ-014 busy  output  1  high in every state except IDLE.
REQ-015 done  output  1  one-cycle pulse at the end of a sweep.

Function
REQ-016 The block SHALL hold NUM_NEURONS potentials in a register array and share one LIF update datapath across them.
REQ-017 FSM states SHALL be IDLE, FETCH, EMIT and DONE.
REQ-018 IDLE: start=1 SHALL clear the neuron index to 0 and move to FETCH next cycle; start is ignored in every other state.
REQ-019 FETCH: input_ready SHALL be 1; on input_valid&input_ready, the selected neuron is updated at that edge.
REQ-020 Update rule: s = min(p + synaptic_input, 2^W-1) (saturating); n = s - DECAY if s >= DECAY, else 0.
REQ-021 If n >= THRESHOLD, the stored potential SHALL become 0, the index is latched into spike_id, and the FSM moves to EMIT; otherwise the stored potential SHALL become n.
REQ-022 After a non-spiking handshake, the FSM SHALL advance: to FETCH with index+1, or to DONE if the index equals NUM_NEURONS-1.
REQ-023 EMIT: spike_valid=1, input_ready=0, and spike_id SHALL be stable until spike_valid&spike_ready; the FSM then advances using the rule of REQ-022.
REQ-024 DONE: done=1 for exactly one cycle, then the FSM returns to IDLE; potentials persist across sweeps.
REQ-025 Throughput SHALL be 1 cycle per non-spiking neuron and at least 2 cycles per spiking neuron.
REQ-026 Minimum sweep length, from start to done, SHALL be NUM_NEURONS+2 cycles.
REQ-027 Outputs input_ready, spike_valid and done SHALL be 0 outside FETCH, EMIT and DONE respectively.

Reset
REQ-028 reset=1 SHALL force IDLE, index 0, all potentials 0, spike_id 0, spike_valid/input_ready/done/busy 0 on the next edge, including mid-sweep.
REQ-029 A pending spike is discarded on reset.
REQ-030 reset SHALL have priority over start and over both handshakes in the same cycle.

Structure
REQ-031 Package snn_pkg SHALL define the FSM state typedef and a function computing the index width from NUM_NEURONS.
REQ-032 The datapath SHALL be a combinational sub-module snn_lif_update with inputs (potential, synaptic_input) and outputs (next_potential, fire), parameterised by width, threshold and decay.
REQ-033 The potential array, FSM, index counter and handshake logic SHALL reside in snn_neuron_scheduler.

Verification (NUM_NEURONS=4, W=8, THRESHOLD=8, DECAY=1)
REQ-034 Sweep with inputs 3,3,3,3 and ready always high: potentials become 2,2,2,2, no spike_valid, and done arrives 6 cycles after start.
REQ-035 Second sweep with inputs 7,0,7,0: spikes on ids 0 and 2 in order, potentials become 0,1,0,1, and the sweep takes 8 cycles.
REQ-036 Saturation: a neuron at potential 2 receives input 255 -> s=255, n=254, a spike is emitted and the potential becomes 0.
REQ-037 Backpressure: spike_ready held low for 5 cycles during EMIT -> spike_valid stays 1, spike_id is unchanged and input_ready stays 0; the FSM proceeds on the cycle after spike_ready rises.
REQ-038 Floor and ignore: a neuron at 0 with input 0 stays at 0; start pulsed while busy causes no second sweep.
REQ-039 Reset while in EMIT for id 1 -> next cycle: IDLE, all potentials 0, spike_valid 0; a fresh sweep with inputs 0 produces no spikes.
